// File: rtl/apb_pkg.sv
// apb_pkg: definitions shared by the APB requester and the completer bench.
//   state_e      - requester FSM states (IDLE, SETUP, ACCESS), 2-bit encoding
//   APB_PADDR_WL - default APB address width
//   APB_PDATA_WL - default APB data width
package apb_pkg;

  localparam int APB_PADDR_WL = 4;
  localparam int APB_PDATA_WL = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

endpackage

// File: rtl/apb_requester_if.sv
// apb_requester_if: command/response stream plus APB bus of the requester.
//   master modport - the requester's view (drives cmd_ready, rsp_*, APB outputs)
//   slave modport  - the environment's view (command source, completer)
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high. The source holds cmd_write/cmd_addr/cmd_wdata
// stable while cmd_valid is high and not yet accepted. rsp_valid is a
// one-cycle pulse with no back-pressure; rsp_rdata/rsp_err are qualified by it.
interface apb_requester_if
  import apb_pkg::*;
#(
  parameter int PADDR_WL = APB_PADDR_WL,
  parameter int PDATA_WL = APB_PDATA_WL
);

  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_write;
  logic [PADDR_WL-1:0] cmd_addr;
  logic [PDATA_WL-1:0] cmd_wdata;

  logic                rsp_valid;
  logic [PDATA_WL-1:0] rsp_rdata;
  logic                rsp_err;

  logic [PADDR_WL-1:0] paddr;
  logic [PDATA_WL-1:0] pwdata;
  logic                pwrite;
  logic                psel;
  logic                penable;
  logic [PDATA_WL-1:0] prdata;
  logic                pready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           paddr, pwdata, pwrite, psel, penable
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           paddr, pwdata, pwrite, psel, penable
  );

endinterface

// File: rtl/apb_requester.sv
// apb_requester: APB initiator issuing one transfer at a time.
//   clk       - single clock, rising edge
//   reset     - synchronous, active-high
//   bus       - apb_requester_if.master: command stream in, response pulse out,
//               APB paddr/pwdata/pwrite/psel/penable out, prdata/pready in
//   dbg_state - current FSM state
// Sequence per transfer: IDLE (accept) -> SETUP -> ACCESS (waits on pready)
// -> IDLE with a one-cycle rsp_valid. All bus outputs are registered.
// Optional macro APB_REQUESTER_TIMEOUT_EN: abort an ACCESS phase that waits
// too long, answering with rsp_err=1.
module apb_requester
  import apb_pkg::*;
#(
  parameter int PADDR_WL       = APB_PADDR_WL,
  parameter int PDATA_WL       = APB_PDATA_WL,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  apb_requester_if.master       bus,
  output state_e                dbg_state
);

  state_e              state_q,     state_d;
  logic                psel_q,      psel_d;
  logic                penable_q,   penable_d;
  logic                pwrite_q,    pwrite_d;
  logic [PADDR_WL-1:0] paddr_q,     paddr_d;
  logic [PDATA_WL-1:0] pwdata_q,    pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [PDATA_WL-1:0] rsp_rdata_q, rsp_rdata_d;

`ifdef APB_REQUESTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_err_q, rsp_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
`ifdef APB_REQUESTER_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_err_d   = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        // cmd_ready is high whenever IDLE and out of reset, so cmd_valid alone
        // qualifies acceptance here; reset overrides in the register block.
        if (bus.cmd_valid) begin
          state_d   = SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = bus.cmd_write;
          paddr_d   = bus.cmd_addr;
          pwdata_d  = bus.cmd_wdata;
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
`ifdef APB_REQUESTER_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end

      ACCESS: begin
        if (bus.pready) begin
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
        end
`ifdef APB_REQUESTER_TIMEOUT_EN
        // pready is tested first, so a completion in the limit cycle wins.
        else if (cnt_q == CNT_LIMIT) begin
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef APB_REQUESTER_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_REQUESTER_TIMEOUT_EN
      cnt_q       <= cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign bus.cmd_ready = (state_q == IDLE) && !reset;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
`ifdef APB_REQUESTER_TIMEOUT_EN
  assign bus.rsp_err   = rsp_err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif
  assign dbg_state     = state_q;

endmodule
